// File: rtl/bram_pkg.sv
// Shared types and constants for the true dual-port block RAM.
// Holds the write-mode enumeration, legal read latencies and clog2.
package bram_pkg;

    typedef enum logic {
        READ_FIRST,
        WRITE_FIRST
    } writeMode_e;

    typedef enum logic {
        CLEAR,
        RUN
    } ctrlState_e;

    localparam int LATENCY_ONE = 1;
    localparam int LATENCY_TWO = 2;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/bram_if.sv
// One access port of the dual-port RAM: request fields in,
// read data and its valid strobe out.
interface bram_if #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4096
);
    localparam int AddrWidth = bram_pkg::clog2(Depth);

    logic                   clockEn;
    logic [DataWidth/8-1:0] write;
    logic [AddrWidth-1:0]   address;
    logic [DataWidth-1:0]   dataIn;
    logic [DataWidth-1:0]   dataOut;
    logic                   valid;

    modport master (
        output clockEn, write, address, dataIn,
        input  dataOut, valid
    );

    modport slave (
        input  clockEn, write, address, dataIn,
        output dataOut, valid
    );

endinterface

// File: rtl/bram_rd_pipe.sv
// Per-port output pipeline: one or two register stages carrying
// the valid strobe and the read word, holding data between strobes.
module bram_rd_pipe
    import bram_pkg::*;
#(
    parameter int DataWidth   = 32,
    parameter int ReadLatency = LATENCY_ONE
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 inValid,
    input  logic [DataWidth-1:0] inData,
    output logic                 outValid,
    output logic [DataWidth-1:0] outData
);

    logic                 stage1Valid;
    logic [DataWidth-1:0] stage1Data;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stage1Valid <= 1'b0;
            stage1Data  <= '0;
        end else begin
            stage1Valid <= inValid;
            if (inValid) stage1Data <= inData;
        end
    end

    if (ReadLatency == LATENCY_TWO) begin : gTwo
        logic                 stage2Valid;
        logic [DataWidth-1:0] stage2Data;

        always_ff @(posedge Clock or negedge ResetN) begin
            if (!ResetN) begin
                stage2Valid <= 1'b0;
                stage2Data  <= '0;
            end else begin
                stage2Valid <= stage1Valid;
                if (stage1Valid) stage2Data <= stage1Data;
            end
        end

        assign outValid = stage2Valid;
        assign outData  = stage2Data;
    end else begin : gOne
        assign outValid = stage1Valid;
        assign outData  = stage1Data;
    end

endmodule

// File: rtl/bram_tdp.sv
// True dual-port RAM with byte enables, port-A collision priority,
// selectable read/write-first behaviour and an optional power-on clear.
module bram_tdp
    import bram_pkg::*;
#(
    parameter int         DataWidth    = 32,
    parameter int         Depth        = 4096,
    parameter int         ReadLatency  = LATENCY_ONE,
    parameter writeMode_e WriteMode    = READ_FIRST,
    parameter bit         ClearOnReset = 1'b1
) (
    input  logic  Clock,
    input  logic  ResetN,
    output logic  Ready,
    bram_if.slave portA,
    bram_if.slave portB
);

    localparam int AddrWidth = clog2(Depth);
    localparam int Bytes     = DataWidth / 8;

    typedef logic [DataWidth-1:0] word_t;

    ctrlState_e           state;
    logic [AddrWidth-1:0] clearAddr;
    logic                 clearEn;
    logic                 acceptA;
    logic                 acceptB;
    logic                 sameAddr;
    word_t                mem [Depth];
    word_t                oldA;
    word_t                oldB;
    word_t                newA;
    word_t                newB;
    word_t                readA;
    word_t                readB;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= CLEAR;
            clearAddr <= '0;
            Ready     <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    if (!ClearOnReset ||
                        clearAddr == AddrWidth'(Depth - 1)) begin
                        state <= RUN;
                        Ready <= 1'b1;
                    end else begin
                        clearAddr <= clearAddr + AddrWidth'(1);
                    end
                end
                RUN: Ready <= 1'b1;
            endcase
        end
    end

    // The async reset also gates the clear so held reset never writes.
    assign clearEn  = ClearOnReset && ResetN && (state == CLEAR);
    assign acceptA  = portA.clockEn && Ready;
    assign acceptB  = portB.clockEn && Ready;
    assign sameAddr = (portA.address == portB.address);

    // Post-write words; A is applied last so it wins shared bytes.
    always_comb begin
        oldA = mem[portA.address];
        oldB = mem[portB.address];
        newA = oldA;
        newB = oldB;
        for (int b = 0; b < Bytes; b++) begin
            if (acceptB && portB.write[b]) begin
                newB[b*8 +: 8] = portB.dataIn[b*8 +: 8];
                if (sameAddr) newA[b*8 +: 8] = portB.dataIn[b*8 +: 8];
            end
        end
        for (int b = 0; b < Bytes; b++) begin
            if (acceptA && portA.write[b]) begin
                newA[b*8 +: 8] = portA.dataIn[b*8 +: 8];
                if (sameAddr) newB[b*8 +: 8] = portA.dataIn[b*8 +: 8];
            end
        end
        readA = (WriteMode == WRITE_FIRST) ? newA : oldA;
        readB = (WriteMode == WRITE_FIRST) ? newB : oldB;
    end

    always_ff @(posedge Clock) begin
        if (clearEn) mem[clearAddr] <= '0;
        if (acceptB && |portB.write) mem[portB.address] <= newB;
        if (acceptA && |portA.write) mem[portA.address] <= newA;
    end

    bram_rd_pipe #(
        .DataWidth  (DataWidth),
        .ReadLatency(ReadLatency)
    ) pipeA (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .inValid (acceptA),
        .inData  (readA),
        .outValid(portA.valid),
        .outData (portA.dataOut)
    );

    bram_rd_pipe #(
        .DataWidth  (DataWidth),
        .ReadLatency(ReadLatency)
    ) pipeB (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .inValid (acceptB),
        .inData  (readB),
        .outValid(portB.valid),
        .outData (portB.dataOut)
    );

endmodule
